poly8_call_driver: RTL and testbench
====================================

// Module: poly8_call_driver
// PURPOSE
//  Initiator for the poly8 HLS component's call/return streaming interface.
//  - Issues a run of COUNT calls with idx = base, base+1, ... and collects each returndata.
//  - Buffers results in order, tags them and accumulates a checksum.
//  - Sits between the host/testbench control logic and the poly8 instance.
// PARAMETERS
//  DATA_W       32  width of idx and returndata
//  CNT_W        16  width of run length, tags and counters
//  FIFO_DEPTH   4   result buffer entries; power of 2, >=2
// PORTS
//  clock        in   1       single clock; all logic rising-edge
//  reset        in   1       asynchronous, active-high; clears all state
//  cfg_go       in   1       1-cycle start pulse for a run
//  cfg_base     in   DATA_W  first idx value, sampled on accepted cfg_go
//  cfg_count    in   CNT_W   number of calls, sampled on accepted cfg_go
//  call_start   out  1       call.valid to poly8
//  call_busy    in   1       call.stall from poly8
//  call_idx     out  DATA_W  idx.data to poly8
//  ret_done     in   1       return.valid from poly8
//  ret_stall    out  1       return.stall to poly8
//  ret_data     in   DATA_W  returndata from poly8
//  res_valid    out  1       result available downstream
//  res_ready    in   1       downstream accepts result
//  res_data     out  DATA_W  result value
//  res_tag      out  CNT_W   0-based position of result in the run
//  run_active   out  1       run in progress
//  run_done     out  1       level; high from run completion until next accepted cfg_go
//  checksum     out  DATA_W  sum mod 2^DATA_W of all returns in current run
//  err_spurious out  1       sticky; return arrived with no outstanding call
// BEHAVIOUR
//  Reset values: all outputs 0; FSM = IDLE; counters, FIFO and checksum cleared.
//  Call handshake: a call fires when call_start && !call_busy.
//  - call_idx is held stable while call_start && call_busy.
//  - call_start never drops before the call fires.
//  Return handshake: a return transfers when ret_done && !ret_stall.
//  - Transferred data is pushed to the FIFO with the next tag; checksum += ret_data.
//  - Returns arrive in issue order.
//  Credit rule: call_start = (state==RUN) && issued<count && (outstanding + fifo_occ) < FIFO_DEPTH.
//  - ret_stall = FIFO full; by the credit rule it is never asserted while a return is owed.
//  FSM:
//  - IDLE -> RUN on cfg_go.
//  - RUN -> DRAIN when issued==count.
//  - DRAIN -> FIN when received==count and FIFO empty.
//  - FIN -> RUN on cfg_go.
//  - cfg_go in RUN or DRAIN is ignored.
//  - cfg_go with count==0: RUN -> DRAIN -> FIN within 2 cycles; no call issued.
//  On accepted cfg_go: issued, received, tags and checksum clear; run_done drops.
//  - run_active is high in RUN and DRAIN.
//  Simultaneous events:
//  - Call fire and return transfer in the same cycle: outstanding unchanged.
//  - FIFO push and pop in the same cycle: allowed when full (pop frees the slot combinationally is NOT allowed; full stalls).
//  Spurious return: ret_done with outstanding==0 is accepted, dropped and sets err_spurious.
//  - ret_stall = 0 in this case; err_spurious clears only on reset.
//  Reset mid-run: immediate abort; returns later produced by poly8 for aborted calls raise err_spurious.
//  idx arithmetic: base + n wraps mod 2^DATA_W. Tags wrap never (n < count <= 2^CNT_W-1).
//  FIFO: show-ahead. res_valid = !empty; pop on res_valid && res_ready; no combinational in->out path.
// STRUCTURE
//  Package poly8_pkg:
//  - DATA_W and CNT_W defaults.
//  - FSM state enum {IDLE, RUN, DRAIN, FIN}.
//  - typedef result_t {tag, data}.
//  Sub-module poly8_ret_fifo: synchronous FIFO of result_t with show-ahead output, full/empty/occupancy, async active-high reset.
//  Top: FSM, issue/receive/outstanding counters, idx generator, checksum.
// TESTING
//  1 base=10,count=3,busy=0,poly8 model latency 2,res_ready=1
//    -> idx 10,11,12 issued; tags 0,1,2; run_done; checksum = sum of model outputs.
//  2 call_busy held high 5 cycles on first call
//    -> call_start and call_idx=10 stable throughout; exactly 3 calls fire total.
//  3 res_ready=0, count=8, FIFO_DEPTH=4
//    -> at most 4 calls before first pop; ret_stall never high while ret_done high; no loss.
//  4 count=0 -> no call_start; run_done within 2 cycles; checksum=0.
//  5 cfg_go pulsed mid-run -> ignored; run completes with original count.
//  6 reset during DRAIN with 2 outstanding, then model returns 2
//    -> outputs 0 after reset; err_spurious=1; FIFO stays empty.
//  7 base=32'hFFFF_FFFF, count=2 -> idx FFFF_FFFF then 0000_0000.

Source files
------------

// File: rtl/poly8_pkg.sv
// Shared types for the poly8 call driver: default widths, FSM states and
// the tagged result record buffered between poly8 and the downstream consumer.
package poly8_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic [DEF_CNT_W-1:0]  tag;
    logic [DEF_DATA_W-1:0] data;
  } result_t;

endpackage

// File: rtl/poly8_ret_fifo.sv
// Show-ahead result FIFO: head entry is visible whenever not empty; a push
// into a full FIFO is dropped even if a pop happens in the same cycle.
module poly8_ret_fifo
  import poly8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  result_t                  wdata,
  input  logic                     pop,
  output result_t                  rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int AW = $clog2(DEPTH);

  result_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is data only; the pointers and occupancy define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/poly8_call_driver.sv
// Drives a run of calls into poly8 (idx = base + n), collects returns in order
// into a tagged result FIFO and keeps a running checksum of the run.
module poly8_call_driver
  import poly8_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_go,
  input  logic [DATA_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic              call_start,
  input  logic              call_busy,
  output logic [DATA_W-1:0] call_idx,
  input  logic              ret_done,
  output logic              ret_stall,
  input  logic [DATA_W-1:0] ret_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [CNT_W-1:0]  res_tag,
  output logic              run_active,
  output logic              run_done,
  output logic [DATA_W-1:0] checksum,
  output logic              err_spurious
);

  localparam int OW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [DATA_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  received;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     occ;
  logic [OW:0]       credit_used;
  logic              fifo_full;
  logic              fifo_empty;
  logic              call_fire;
  logic              ret_xfer;
  logic              ret_push;
  result_t           fifo_wdata;
  result_t           fifo_rdata;

  // Every issued call reserves a FIFO slot, so a return is never stalled.
  assign credit_used = {1'b0, outstanding} + {1'b0, occ};
  assign call_start  = (state == RUN) && (issued < count_q)
                       && (credit_used < (OW+1)'(FIFO_DEPTH));
  assign call_idx    = base_q + DATA_W'(issued);
  assign call_fire   = call_start && !call_busy;

  assign ret_stall   = fifo_full && (outstanding != '0);
  assign ret_xfer    = ret_done && !ret_stall;
  assign ret_push    = ret_xfer && (outstanding != '0);

  assign fifo_wdata.tag  = DEF_CNT_W'(received);
  assign fifo_wdata.data = DEF_DATA_W'(ret_data);

  assign res_valid = !fifo_empty;
  assign res_data  = DATA_W'(fifo_rdata.data);
  assign res_tag   = CNT_W'(fifo_rdata.tag);

  poly8_ret_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (ret_push),
    .wdata (fifo_wdata),
    .pop   (res_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .occ   (occ)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      base_q       <= '0;
      count_q      <= '0;
      issued       <= '0;
      received     <= '0;
      outstanding  <= '0;
      checksum     <= '0;
      run_active   <= 1'b0;
      run_done     <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (call_fire) issued <= issued + 1'b1;
      if (ret_push) begin
        received <= received + 1'b1;
        checksum <= checksum + ret_data;
      end
      // A return with nothing owed is taken off the bus and discarded.
      if (ret_xfer && (outstanding == '0)) err_spurious <= 1'b1;
      case ({call_fire, ret_push})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase

      case (state)
        IDLE, FIN: begin
          if (cfg_go) begin
            state      <= RUN;
            base_q     <= cfg_base;
            count_q    <= cfg_count;
            issued     <= '0;
            received   <= '0;
            checksum   <= '0;
            run_active <= 1'b1;
            run_done   <= 1'b0;
          end
        end
        RUN: begin
          if (issued == count_q) state <= DRAIN;
        end
        DRAIN: begin
          if ((received == count_q) && fifo_empty) begin
            state      <= FIN;
            run_active <= 1'b0;
            run_done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly8_call_driver.sv
// Scoreboard bench for poly8_call_driver with a behavioural poly8 (3*idx+5,
// configurable latency) answering the call/return interface.
module tb_poly8_call_driver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_go = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [15:0] cfg_count = '0;
  logic        call_start;
  logic        call_busy = 1'b0;
  logic [31:0] call_idx;
  logic        ret_done = 1'b0;
  logic        ret_stall;
  logic [31:0] ret_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic [15:0] res_tag;
  logic        run_active;
  logic        run_done;
  logic [31:0] checksum;
  logic        err_spurious;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 2;
  int fires_total = 0;
  int pops_total = 0;

  logic [31:0] exp_idx_q [$];
  logic [15:0] exp_tag_q [$];
  logic [31:0] exp_dat_q [$];
  logic [31:0] pend_data [$];
  int          pend_due  [$];

  logic [31:0] t3_dat [8] = '{32'd305, 32'd308, 32'd311, 32'd314,
                              32'd317, 32'd320, 32'd323, 32'd326};

  poly8_call_driver #(
    .DATA_W     (32),
    .CNT_W      (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_go       (cfg_go),
    .cfg_base     (cfg_base),
    .cfg_count    (cfg_count),
    .call_start   (call_start),
    .call_busy    (call_busy),
    .call_idx     (call_idx),
    .ret_done     (ret_done),
    .ret_stall    (ret_stall),
    .ret_data     (ret_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_tag      (res_tag),
    .run_active   (run_active),
    .run_done     (run_done),
    .checksum     (checksum),
    .err_spurious (err_spurious)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] idx, input logic [15:0] tag, input logic [31:0] dat);
    exp_idx_q.push_back(idx);
    exp_tag_q.push_back(tag);
    exp_dat_q.push_back(dat);
  endtask

  task automatic go(input logic [31:0] b, input logic [15:0] c);
    cfg_base  = b;
    cfg_count = c;
    cfg_go    = 1'b1;
    @(posedge clock); #1;
    cfg_go    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!run_done && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    chk({name, "_run_done"}, run_done, 1);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_call_start"}, call_start, 0);
    chk({name, "_call_idx"}, call_idx, 0);
    chk({name, "_ret_stall"}, ret_stall, 0);
    chk({name, "_res_valid"}, res_valid, 0);
    chk({name, "_res_data"}, res_data, 0);
    chk({name, "_res_tag"}, res_tag, 0);
    chk({name, "_run_active"}, run_active, 0);
    chk({name, "_run_done"}, run_done, 0);
    chk({name, "_checksum"}, checksum, 0);
    chk({name, "_err_spurious"}, err_spurious, 0);
  endtask

  // poly8 model: presents the oldest pending result once its latency expires
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (pend_due.size() != 0 && cyc >= pend_due[0]) begin
        ret_done = 1'b1;
        ret_data = pend_data[0];
      end else begin
        ret_done = 1'b0;
        ret_data = '0;
      end
    end
  end

  // Monitor: observes handshakes mid-cycle and checks against the scoreboard
  initial begin
    logic [31:0] v;
    logic [31:0] e_idx;
    logic [15:0] e_tag;
    logic [31:0] e_dat;
    forever begin
      @(negedge clock);
      if (call_start && !call_busy) begin
        fires_total++;
        v = call_idx * 32'd3 + 32'd5;
        pend_data.push_back(v);
        pend_due.push_back(cyc + lat);
        if (exp_idx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL call_unexpected actual_idx=%0h required=no call", call_idx);
        end else begin
          e_idx = exp_idx_q.pop_front();
          chk("call_idx", call_idx, e_idx);
        end
      end
      if (ret_done) begin
        chk("ret_stall_while_done", ret_stall, 0);
        if (!ret_stall && pend_due.size() != 0) begin
          void'(pend_data.pop_front());
          void'(pend_due.pop_front());
        end
      end
      if (res_valid && res_ready) begin
        pops_total++;
        if (exp_dat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected actual=%0h/%0h required=no result", res_tag, res_data);
        end else begin
          e_tag = exp_tag_q.pop_front();
          e_dat = exp_dat_q.pop_front();
          chk("res_tag", res_tag, e_tag);
          chk("res_data", res_data, e_dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int psnap;
    int n;

    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // 1: basic run, latency 2
    push_exp(32'd10, 16'd0, 32'd35);
    push_exp(32'd11, 16'd1, 32'd38);
    push_exp(32'd12, 16'd2, 32'd41);
    snap = fires_total;
    go(32'd10, 16'd3);
    chk("t1_run_active", run_active, 1);
    wait_done("t1", 40);
    chk("t1_fires", fires_total - snap, 3);
    chk("t1_checksum", checksum, 32'd114);
    chk("t1_run_active_end", run_active, 0);

    // 2: call_busy held on the first call
    push_exp(32'd10, 16'd0, 32'd35);
    push_exp(32'd11, 16'd1, 32'd38);
    push_exp(32'd12, 16'd2, 32'd41);
    call_busy = 1'b1;
    snap = fires_total;
    go(32'd10, 16'd3);
    for (int i = 0; i < 5; i++) begin
      chk("t2_call_start_held", call_start, 1);
      chk("t2_call_idx_held", call_idx, 32'd10);
      @(posedge clock); #1;
    end
    call_busy = 1'b0;
    wait_done("t2", 40);
    chk("t2_fires", fires_total - snap, 3);
    chk("t2_checksum", checksum, 32'd114);

    // 3: back-pressure from downstream limits calls to the FIFO depth
    for (int i = 0; i < 8; i++) push_exp(32'd100 + 32'(i), 16'(i), t3_dat[i]);
    res_ready = 1'b0;
    snap  = fires_total;
    psnap = pops_total;
    go(32'd100, 16'd8);
    repeat (20) @(posedge clock);
    #1;
    chk("t3_fires_before_pop", fires_total - snap, 4);
    chk("t3_pops_before_ready", pops_total - psnap, 0);
    chk("t3_res_valid", res_valid, 1);
    chk("t3_head_tag", res_tag, 0);
    res_ready = 1'b1;
    wait_done("t3", 100);
    chk("t3_fires", fires_total - snap, 8);
    chk("t3_checksum", checksum, 32'd2524);

    // 4: empty run
    snap = fires_total;
    go(32'd7, 16'd0);
    wait_done("t4", 2);
    chk("t4_fires", fires_total - snap, 0);
    chk("t4_checksum", checksum, 32'd0);

    // 5: cfg_go during a run is ignored
    push_exp(32'd20, 16'd0, 32'd65);
    push_exp(32'd21, 16'd1, 32'd68);
    push_exp(32'd22, 16'd2, 32'd71);
    push_exp(32'd23, 16'd3, 32'd74);
    snap = fires_total;
    go(32'd20, 16'd4);
    @(posedge clock); #1;
    go(32'd500, 16'd9);
    wait_done("t5", 60);
    chk("t5_fires", fires_total - snap, 4);
    chk("t5_checksum", checksum, 32'd278);

    // 7: idx wraps past all-ones
    push_exp(32'hFFFF_FFFF, 16'd0, 32'd2);
    push_exp(32'h0000_0000, 16'd1, 32'd5);
    go(32'hFFFF_FFFF, 16'd2);
    wait_done("t7", 40);
    chk("t7_checksum", checksum, 32'd7);
    chk("t7_err_spurious", err_spurious, 0);
    chk("sb_results_drained", exp_dat_q.size(), 0);

    // 6: reset during DRAIN with two calls still owed
    lat = 6;
    exp_idx_q.push_back(32'd200);
    exp_idx_q.push_back(32'd201);
    snap = fires_total;
    go(32'd200, 16'd2);
    n = 0;
    while (fires_total < snap + 2 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("t6_fires", fires_total - snap, 2);
    @(posedge clock); #1;
    chk("t6_drain_active", run_active, 1);
    chk("t6_drain_no_call", call_start, 0);
    reset = 1'b1;
    #1;
    check_zero("t6_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    chk("t6_err_spurious", err_spurious, 1);
    chk("t6_res_valid", res_valid, 0);
    chk("t6_returns_consumed", pend_due.size(), 0);
    chk("t6_run_active", run_active, 0);
    chk("t6_checksum", checksum, 0);
    chk("sb_idx_drained", exp_idx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
